// File: rtl/quick_spi_arbiter.sv
// rtl/quick_spi_arbiter.sv - round-robin arbiter sharing one quick_spi master
// Grants one client at a time, launches the master and returns data or a timeout error.
module quick_spi_arbiter #(
  parameter int NUM_REQUESTERS      = 4,
  parameter int NUMBER_OF_SLAVES    = 2,
  parameter int INCOMING_DATA_WIDTH = 8,
  parameter int OUTGOING_DATA_WIDTH = 16,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic [NUM_REQUESTERS-1:0]                     req,
  input  logic [NUM_REQUESTERS*NUMBER_OF_SLAVES-1:0]    req_slave,
  input  logic [NUM_REQUESTERS-1:0]                     req_operation,
  input  logic [NUM_REQUESTERS*OUTGOING_DATA_WIDTH-1:0] req_outgoing_data,
  output logic [NUM_REQUESTERS-1:0]                     gnt,
  output logic [NUM_REQUESTERS-1:0]                     done,
  output logic [INCOMING_DATA_WIDTH-1:0]                rsp_data,
  output logic                                          rsp_error,
  output logic                                          spi_start_transaction,
  output logic [NUMBER_OF_SLAVES-1:0]                   spi_slave,
  output logic                                          spi_operation,
  output logic [OUTGOING_DATA_WIDTH-1:0]                spi_outgoing_data,
  input  logic                                          spi_end_of_transaction,
  input  logic [INCOMING_DATA_WIDTH-1:0]                spi_incoming_data
);
  localparam int N  = NUM_REQUESTERS;
  localparam int S  = NUMBER_OF_SLAVES;
  localparam int IW = INCOMING_DATA_WIDTH;
  localparam int OW = OUTGOING_DATA_WIDTH;
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_COMPLETE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d, done_q, done_d;
  logic [IW-1:0]   rsp_data_q, rsp_data_d;
  logic            rsp_error_q, rsp_error_d;
  logic            start_q, start_d;
  logic [S-1:0]    slave_q, slave_d;
  logic            op_q, op_d;
  logic [OW-1:0]   wdata_q, wdata_d;
  logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            eot_q;

  logic            any_req, eot_rise;
  logic [PW-1:0]   pick;
  logic [PW:0]     sum;
  logic [S-1:0]    pick_slave;
  logic            pick_op;
  logic [OW-1:0]   pick_wdata;

  assign eot_rise = spi_end_of_transaction & ~eot_q;

  // Scan downward so the last hit written is the nearest set bit at or after ptr.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    sum     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      if (req[sum[PW-1:0]]) begin
        pick    = sum[PW-1:0];
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    pick_slave = '0;
    pick_op    = 1'b0;
    pick_wdata = '0;
    for (int i = 0; i < N; i++) begin
      if (PW'(i) == pick) begin
        pick_slave = req_slave[i*S +: S];
        pick_op    = req_operation[i];
        pick_wdata = req_outgoing_data[i*OW +: OW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    start_d     = 1'b0;
    slave_d     = slave_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          win_d   = pick;
          gnt_d   = N'(1) << pick;
          slave_d = pick_slave;
          op_d    = pick_op;
          wdata_d = pick_wdata;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A completion edge beats an expiring watchdog in the same cycle.
        if (eot_rise) begin
          rsp_data_d  = spi_incoming_data;
          rsp_error_d = 1'b0;
          done_d      = gnt_q;
          state_d     = S_COMPLETE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          done_d      = gnt_q;
          state_d     = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        ptr_d       = (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
        gnt_d       = '0;
        rsp_error_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      start_q     <= 1'b0;
      slave_q     <= '0;
      op_q        <= 1'b0;
      wdata_q     <= '0;
      ptr_q       <= '0;
      win_q       <= '0;
      cnt_q       <= '0;
      eot_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      start_q     <= start_d;
      slave_q     <= slave_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      eot_q       <= spi_end_of_transaction;
    end
  end

  assign gnt                   = gnt_q;
  assign done                  = done_q;
  assign rsp_data              = rsp_data_q;
  assign rsp_error             = rsp_error_q;
  assign spi_start_transaction = start_q;
  assign spi_slave             = slave_q;
  assign spi_operation         = op_q;
  assign spi_outgoing_data     = wdata_q;

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// tb/tb_quick_spi_arbiter.sv - scoreboard bench for quick_spi_arbiter
// Clients and a master model drive the DUT; a monitor checks grants, starts and completions.
module tb_quick_spi_arbiter;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int IW = 8;
  localparam int OW = 16;
  localparam int TO = 16;
  localparam int K_NORMAL = 0;
  localparam int K_STICKY = 1;
  localparam int K_KEEP   = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*S-1:0]  req_slave = '0;
  logic [N-1:0]    req_operation = '0;
  logic [N*OW-1:0] req_outgoing_data = '0;
  logic [N-1:0]    gnt, done;
  logic [IW-1:0]   rsp_data;
  logic            rsp_error, spi_start_transaction, spi_operation;
  logic [S-1:0]    spi_slave;
  logic [OW-1:0]   spi_outgoing_data;
  logic            spi_end_of_transaction = 1'b0;
  logic [IW-1:0]   spi_incoming_data = '0;

  typedef struct {
    int            client;
    logic [S-1:0]  slave;
    logic          op;
    logic [OW-1:0] wdata;
    int            kind;
    int            lat;
    logic [IW-1:0] rdata;
  } txn_t;

  txn_t cmdq[N][$];
  txn_t exp_q[$];
  txn_t mq[$];

  int checks = 0, failures = 0, cyc = 0;
  int round_cyc = 0, last_done = -100, gnt_cyc = 0, start_cyc = 0, model_ptr = 0;
  logic [N-1:0] prev_gnt = '0;

  quick_spi_arbiter #(
    .NUM_REQUESTERS(N), .NUMBER_OF_SLAVES(S), .INCOMING_DATA_WIDTH(IW),
    .OUTGOING_DATA_WIDTH(OW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_slave(req_slave),
    .req_operation(req_operation), .req_outgoing_data(req_outgoing_data),
    .gnt(gnt), .done(done), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .spi_start_transaction(spi_start_transaction), .spi_slave(spi_slave),
    .spi_operation(spi_operation), .spi_outgoing_data(spi_outgoing_data),
    .spi_end_of_transaction(spi_end_of_transaction), .spi_incoming_data(spi_incoming_data)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [N-1:0] oh(input int c);
    return N'(1) << c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(0));
    chk({tag, "_rsp_error"}, 32'(rsp_error), 32'(0));
    chk({tag, "_start"}, 32'(spi_start_transaction), 32'(0));
    chk({tag, "_spi_slave"}, 32'(spi_slave), 32'(0));
    chk({tag, "_spi_op"}, 32'(spi_operation), 32'(0));
    chk({tag, "_spi_wdata"}, 32'(spi_outgoing_data), 32'(0));
  endtask

  // Client ports and the SPI master model.
  initial begin : agent_proc
    int   m_cnt;
    bit   m_active, m_sticky, eot_clr;
    logic [IW-1:0] m_data;
    txn_t p;
    m_cnt = 0; m_active = 0; m_sticky = 0; eot_clr = 0; m_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        req = '0;
        spi_end_of_transaction = 1'b0;
        m_active = 0;
        eot_clr = 0;
      end else begin
        if (eot_clr) begin
          spi_end_of_transaction = 1'b0;
          eot_clr = 0;
        end
        if (spi_start_transaction) begin
          if (mq.size() > 0) begin
            p = mq.pop_front();
            m_active = (p.kind != K_KEEP);
            m_sticky = (p.kind == K_STICKY);
            m_cnt    = p.lat;
            m_data   = p.rdata;
            if (m_active) spi_end_of_transaction = 1'b0;
          end else begin
            m_active = 0;
          end
        end else if (m_active) begin
          m_cnt--;
          if (m_cnt == 0) begin
            spi_end_of_transaction = 1'b1;
            spi_incoming_data = m_data;
            m_active = 0;
            if (!m_sticky) eot_clr = 1;
          end
        end
        for (int c = 0; c < N; c++) begin
          if (done[c] && cmdq[c].size() > 0) void'(cmdq[c].pop_front());
          if (gnt[c] && !done[c]) begin
            req[c] = (c == N - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            req_slave[c*S +: S] = S'($urandom);
            req_operation[c] = 1'($urandom);
            req_outgoing_data[c*OW +: OW] = OW'($urandom);
          end else if (cmdq[c].size() > 0) begin
            req[c] = 1'b1;
            req_slave[c*S +: S] = cmdq[c][0].slave;
            req_operation[c] = cmdq[c][0].op;
            req_outgoing_data[c*OW +: OW] = cmdq[c][0].wdata;
          end else begin
            req[c] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops expectations as the DUT shows grants, starts and completions.
  initial begin : monitor_proc
    txn_t e;
    int   exp_g;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_gnt = '0;
      end else begin
        if (gnt != '0 && prev_gnt == '0) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_gnt: got %b expected none", gnt);
          end else begin
            chk("gnt_onehot", 32'(gnt), 32'(oh(exp_q[0].client)));
            exp_g = (round_cyc + 1 > last_done + 2) ? round_cyc + 1 : last_done + 2;
            chk("gnt_cycle", cyc, exp_g);
          end
          gnt_cyc = cyc;
        end
        if (spi_start_transaction) begin
          chk("start_cycle", cyc, gnt_cyc + 1);
          start_cyc = cyc;
          if (exp_q.size() > 0) begin
            chk("spi_slave", 32'(spi_slave), 32'(exp_q[0].slave));
            chk("spi_operation", 32'(spi_operation), 32'(exp_q[0].op));
            chk("spi_outgoing", 32'(spi_outgoing_data), 32'(exp_q[0].wdata));
          end
        end
        if (done != '0) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done: got %b expected none", done);
          end else begin
            e = exp_q.pop_front();
            chk("done_onehot", 32'(done), 32'(oh(e.client)));
            chk("gnt_in_done", 32'(gnt), 32'(oh(e.client)));
            chk("rsp_data", 32'(rsp_data), (e.kind == K_KEEP) ? 32'(0) : 32'(e.rdata));
            chk("rsp_error", 32'(rsp_error), (e.kind == K_KEEP) ? 32'(1) : 32'(0));
            chk("spi_outgoing_held", 32'(spi_outgoing_data), 32'(e.wdata));
            chk("done_latency", cyc - start_cyc, (e.kind == K_KEEP) ? TO : e.lat + 1);
            last_done = cyc;
          end
        end
        prev_gnt = gnt;
      end
    end
  end

  task automatic add_cmd(input int c, input int slave, input int op, input int wdata,
                         input int rdata, input int kind, input int lat);
    txn_t t;
    t.client = c; t.slave = S'(slave); t.op = 1'(op); t.wdata = OW'(wdata);
    t.rdata = IW'(rdata); t.kind = kind; t.lat = lat;
    cmdq[c].push_back(t);
  endtask

  task automatic add_rand(input int c);
    add_cmd(c, $urandom, $urandom, $urandom, $urandom,
            ($urandom_range(0, 5) == 0) ? K_KEEP : K_NORMAL, $urandom_range(1, 15));
  endtask

  // Reference order: each grant goes to the nearest pending client at or after the pointer.
  task automatic launch();
    int rem[N];
    int idx[N];
    int left, w, c;
    left = 0;
    for (int k = 0; k < N; k++) begin
      rem[k] = cmdq[k].size();
      idx[k] = 0;
      left += rem[k];
    end
    while (left > 0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        c = (model_ptr + k) % N;
        if (w < 0 && rem[c] > 0) w = c;
      end
      exp_q.push_back(cmdq[w][idx[w]]);
      mq.push_back(cmdq[w][idx[w]]);
      idx[w]++; rem[w]--; left--;
      model_ptr = (w + 1) % N;
    end
    round_cyc = cyc;
  endtask

  task automatic flush_all();
    exp_q.delete();
    mq.delete();
    for (int k = 0; k < N; k++) cmdq[k].delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
      flush_all();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic begin_round();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim_proc
    int n, picked;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);

    begin_round();
    add_cmd(0, 1, 0, 16'h0000, 8'hA5, K_NORMAL, 3);
    launch();
    wait_idle("single_read");

    begin_round();
    add_cmd(1, 2, 1, 16'h1234, 8'h11, K_NORMAL, 2);
    add_cmd(2, 3, 1, 16'hBEEF, 8'h22, K_NORMAL, 4);
    launch();
    wait_idle("pair");

    begin_round();
    add_cmd(3, 0, 0, 16'h0303, 8'h33, K_NORMAL, 1);
    launch();
    wait_idle("client3");

    begin_round();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < N; c++) add_rand(c);
    launch();
    wait_idle("all_four");

    begin_round();
    add_cmd(2, 1, 0, 16'h0202, 8'h5A, K_KEEP, 1);
    launch();
    wait_idle("timeout");

    begin_round();
    add_cmd(0, 1, 0, 16'h0A0A, 8'h77, K_STICKY, 2);
    add_cmd(0, 2, 1, 16'h0B0B, 8'h88, K_KEEP, 1);
    launch();
    wait_idle("sticky");

    begin_round();
    add_cmd(1, 0, 1, 16'h0C0C, 8'h99, K_NORMAL, 1);
    launch();
    wait_idle("after_sticky");

    begin_round();
    add_cmd(3, 3, 1, 16'hD00D, 8'h3C, K_NORMAL, 15);
    launch();
    wait_idle("eot_vs_timeout");

    for (int r = 0; r < 12; r++) begin
      begin_round();
      picked = 0;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          n = $urandom_range(1, 3);
          for (int k = 0; k < n; k++) add_rand(c);
          picked = 1;
        end
      end
      if (picked == 0) add_rand($urandom_range(0, N - 1));
      launch();
      wait_idle("random");
    end

    begin_round();
    add_cmd(1, 1, 0, 16'h1111, 8'h44, K_NORMAL, 2);
    launch();
    wait_idle("pre_reset");

    begin_round();
    add_cmd(1, 2, 1, 16'h2222, 8'h55, K_KEEP, 1);
    launch();
    n = 0;
    while (!spi_start_transaction && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!spi_start_transaction) begin
      checks++; failures++;
      $display("FAIL abort_start: got 0 expected 1");
    end
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    flush_all();
    model_ptr = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    begin_round();
    add_cmd(1, 1, 1, 16'h4321, 8'h6E, K_NORMAL, 3);
    add_cmd(3, 2, 0, 16'h8765, 8'h7F, K_NORMAL, 5);
    launch();
    wait_idle("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quick_spi_arbiter.md
Name: quick_spi_arbiter

Overview:
Round-robin arbiter and sequencer that shares one quick_spi master between NUM_REQUESTERS clients. It latches the winning client's command (slave, operation, outgoing word) and issues a one-cycle start to the master. It then waits for the master's end-of-transaction edge and returns the incoming data with a per-client done pulse. A watchdog aborts transactions that never complete.

Parameters:
NUM_REQUESTERS, 4, number of client ports (2..16)
NUMBER_OF_SLAVES, 2, width of slave select field, passed unchanged to master
INCOMING_DATA_WIDTH, 8, read data width
OUTGOING_DATA_WIDTH, 16, write data width
TIMEOUT_CYCLES, 1024, clk cycles in WAIT before abort (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQUESTERS  per-client request level, held until done
req_slave  in  NUM_REQUESTERS*NUMBER_OF_SLAVES  flattened slave fields, client i at [i*S +: S]
req_operation  in  NUM_REQUESTERS  per-client op, 0=READ 1=WRITE
req_outgoing_data  in  NUM_REQUESTERS*OUTGOING_DATA_WIDTH  flattened write words
gnt  out  NUM_REQUESTERS  one-hot grant, high from GRANT through COMPLETE
done  out  NUM_REQUESTERS  one-cycle completion pulse to granted client
rsp_data  out  INCOMING_DATA_WIDTH  read data, valid in done cycle
rsp_error  out  1  high in done cycle when transaction timed out
spi_start_transaction  out  1  start pulse to master
spi_slave  out  NUMBER_OF_SLAVES  latched slave field
spi_operation  out  1  latched operation
spi_outgoing_data  out  OUTGOING_DATA_WIDTH  latched write word
spi_end_of_transaction  in  1  master completion flag (level, may be sticky)
spi_incoming_data  in  INCOMING_DATA_WIDTH  master read data

Behaviour:
- Reset (async, any state): state=IDLE; gnt, done, rsp_data, rsp_error, spi_start_transaction, spi_slave, spi_operation, spi_outgoing_data all 0; priority pointer ptr=0; eot_q=0; timeout counter=0.
- eot_q registers spi_end_of_transaction every cycle. eot_rise = spi_end_of_transaction & ~eot_q. Only the rising edge counts, so a sticky master flag cannot complete a later transaction.
- FSM IDLE: if any req, choose winner w = first set bit searching from ptr upward with wrap modulo NUM_REQUESTERS. Latch w's slave/op/data into spi_* regs. Set gnt[w]. Go to GRANT. No req: stay.
- GRANT (1 cycle): spi_start_transaction=1; clear counter; go to WAIT. Latency is req high in IDLE -> gnt next cycle -> start the cycle after.
- WAIT: spi_start_transaction=0; counter increments each cycle. On eot_rise: capture spi_incoming_data into rsp_data, rsp_error=0, go to COMPLETE. Else if counter==TIMEOUT_CYCLES-1: rsp_data=0, rsp_error=1, go to COMPLETE. If eot_rise and timeout occur in the same cycle, eot_rise wins.
- COMPLETE (1 cycle): done[w]=1; ptr=(w+1) mod N; go to IDLE. On the exit edge, gnt, done and rsp_error clear. rsp_data holds until the next completion.
- Minimum of one IDLE cycle between transactions. Back-to-back period is 4 cycles plus master time.
- spi_* command regs stay stable from GRANT until the next IDLE grant.
- Client deasserting req after grant is ignored: the transaction finishes and done still pulses. A new req from the same client in the done cycle is not seen until IDLE.
- req changes during WAIT never alter the latched command or gnt.
- Fairness: a continuously requesting client is served within NUM_REQUESTERS grants.
- Out-of-range slave values are passed through unchecked.

Test Plan:
- Client 0 only, READ, slave=1 -> gnt=0001 next cycle; spi_start one cycle later with spi_slave=1, spi_operation=0; model raises eot with data 8'hA5 -> done=0001, rsp_data=A5, rsp_error=0.
- Clients 1 and 2 request together from reset (ptr=0) -> client 1 served first, then 2; ptr=3 afterwards; spi_outgoing_data matches each client's word (16'h1234, 16'hBEEF).
- All four hold req continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
- Model never asserts eot, TIMEOUT_CYCLES=16 -> done pulses 16 cycles after WAIT entry with rsp_error=1 and rsp_data=0. A sticky eot left high from an earlier transfer must not complete the next one.
- Assert reset_n low mid-WAIT (async, between clk edges) -> all outputs 0 immediately. After release, a fresh req is granted normally with ptr=0.
- Client 3 drops req during WAIT -> done[3] still pulses on eot_rise. The eot edge and timeout on the same cycle give rsp_error=0.
